// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int unsigned IFQ_DATA_LEN = 32;
    localparam int unsigned IFQ_ADDR_LEN = 32;
    // Canonical NOP (addi x0,x0,0), also used by ID and commit.
    localparam logic [31:0] IFQ_NOP_INST = 32'h0000_0013;

    // Queue operation for a given cycle, encoded as {pop, push}.
    typedef enum logic [1:0] {
        Q_HOLD = 2'b00,
        Q_PUSH = 2'b01,
        Q_POP  = 2'b10,
        Q_SWAP = 2'b11
    } q_op_e;

    function automatic q_op_e q_op(input logic push, input logic pop);
        return q_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module fifo_mem_ram
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = IFQ_DATA_LEN + IFQ_ADDR_LEN
)(
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the offered entry on the rising edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// In-order FIFO between instruction fetch and ID; presents NOP when empty.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned         DEPTH    = 4,
    parameter int unsigned         DATA_LEN = IFQ_DATA_LEN,
    parameter int unsigned         ADDR_LEN = IFQ_ADDR_LEN,
    parameter logic [DATA_LEN-1:0] NOP_INST = DATA_LEN'(IFQ_NOP_INST)
)(
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     imem_valid_i,
    input  logic [DATA_LEN-1:0]      imem_inst_i,
    input  logic [ADDR_LEN-1:0]      imem_pc_i,
    output logic                     imem_ready_o,
    input  logic                     kill_IF,
    input  logic                     stall_ID,
    output logic [DATA_LEN-1:0]      id_inst_o,
    output logic [ADDR_LEN-1:0]      id_pc_o,
    output logic                     id_valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = DATA_LEN + ADDR_LEN;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    q_op_e              op;
    logic [ENTRY_W-1:0] head_entry;

    // Handshakes depend on registered state only (no input-to-ready path).
    assign imem_ready_o = (count_q != FULL_CNT);
    assign id_valid_o   = (count_q != '0);
    assign push         = imem_valid_i & imem_ready_o & ~kill_IF;
    assign pop          = id_valid_o & ~stall_ID & ~kill_IF;
    assign op           = q_op(push, pop);

    // Next pointers/occupancy; kill flushes everything and overrides push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (kill_IF) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (op)
                Q_PUSH: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                end
                Q_POP: begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                end
                Q_SWAP: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Pointer and occupancy registers, asynchronously cleared.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({imem_inst_i, imem_pc_i}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_entry)
    );

    assign id_inst_o = id_valid_o ? head_entry[ENTRY_W-1 -: DATA_LEN] : NOP_INST;
    assign id_pc_o   = id_valid_o ? head_entry[ADDR_LEN-1:0] : '0;
    assign count_o   = count_q;

endmodule
